// File: rtl/i2c_reg_target.sv
// I2C target with a 256x8 register file (ADV7513-style register interface model).
// Define I2C_RDBACK_EN to ACK R/W=1 addresses and serve pointer-based reads.
module i2c_reg_target #(
  parameter logic [6:0] DEV_ADDR   = 7'h39,
  parameter int         FILTER_LEN = 4
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SDA_OE,
  output logic       WR_STB,
  output logic [7:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  input  logic [7:0] HOST_ADDR,
  output logic [7:0] HOST_RDATA,
  output logic       BUSY
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, SUB, SUB_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
  } state_t;

`ifdef I2C_RDBACK_EN
  localparam logic RdEn = 1'b1;
`else
  localparam logic RdEn = 1'b0;
`endif
  localparam logic [3:0] FiltMax = 4'(FILTER_LEN - 1);

  // Index 0 carries SCL, index 1 carries SDA; the idle bus level is high.
  logic [1:0] sync1_q, sync2_q, filt_q, prev_q;
  logic [3:0] fcnt_q [2];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      prev_q  <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      sync1_q <= {SDA_IN, SCL_IN};
      sync2_q <= sync1_q;
      prev_q  <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FiltMax) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 4'd1;
        end
      end
    end
  end

  logic scl, sda, sclRise, sclFall, startCond, stopCond;
  assign scl       = filt_q[0];
  assign sda       = filt_q[1];
  assign sclRise   = scl & ~prev_q[0];
  assign sclFall   = ~scl & prev_q[0];
  assign startCond = scl & prev_q[0] & prev_q[1] & ~sda;
  assign stopCond  = scl & prev_q[0] & ~prev_q[1] & sda;

  state_t     state_q, state_d;
  logic [3:0] bitCnt_q, bitCnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       sdaOe_q, sdaOe_d;
  logic       wrEn;
  logic [7:0] byteIn;
  logic [7:0] regs_q [256];
  logic       wrStb_q;
  logic [7:0] wrAddr_q, wrData_q, hostRdata_q;

  assign byteIn = {shift_q[6:0], sda};

  // Next-state logic: START/STOP override every state, bits move on filtered SCL edges.
  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    sdaOe_d  = sdaOe_q;
    wrEn     = 1'b0;
    if (startCond) begin
      state_d  = DEV;
      bitCnt_d = '0;
      sdaOe_d  = 1'b0;
    end else if (stopCond) begin
      state_d = IDLE;
      sdaOe_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, IGNORE: ;
        DEV, SUB, WR: begin
          if (sclRise) begin
            shift_d  = byteIn;
            bitCnt_d = bitCnt_q + 4'd1;
            if (state_q == WR && bitCnt_q == 4'd7) begin
              wrEn  = 1'b1;
              ptr_d = ptr_q + 8'd1;
            end
          end else if (sclFall && bitCnt_q == 4'd8) begin
            bitCnt_d = '0;
            sdaOe_d  = 1'b1;
            if (state_q == DEV) begin
              if (shift_q[7:1] == DEV_ADDR && (!shift_q[0] || RdEn)) begin
                state_d = DEV_ACK;
              end else begin
                state_d = IGNORE;
                sdaOe_d = 1'b0;
              end
            end else if (state_q == SUB) begin
              ptr_d   = shift_q;
              state_d = SUB_ACK;
            end else begin
              state_d = WR_ACK;
            end
          end
        end
        DEV_ACK: begin
          if (sclFall) begin
            bitCnt_d = '0;
            state_d  = SUB;
            sdaOe_d  = 1'b0;
`ifdef I2C_RDBACK_EN
            if (shift_q[0]) begin
              state_d = RD;
              shift_d = regs_q[ptr_q];
              sdaOe_d = ~regs_q[ptr_q][7];
            end
`endif
          end
        end
        SUB_ACK, WR_ACK: begin
          if (sclFall) begin
            state_d  = WR;
            bitCnt_d = '0;
            sdaOe_d  = 1'b0;
          end
        end
`ifdef I2C_RDBACK_EN
        RD: begin
          if (sclRise) begin
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (sclFall) begin
            if (bitCnt_q == 4'd8) begin
              state_d  = RD_ACK;
              bitCnt_d = '0;
              sdaOe_d  = 1'b0;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              sdaOe_d = ~shift_q[6];
            end
          end
        end
        // A count of 9 marks a master ACK waiting for the next SCL fall.
        RD_ACK: begin
          if (sclRise) begin
            ptr_d = ptr_q + 8'd1;
            if (sda) state_d = IGNORE;
            else     bitCnt_d = 4'd9;
          end else if (sclFall && bitCnt_q == 4'd9) begin
            state_d  = RD;
            bitCnt_d = '0;
            shift_d  = regs_q[ptr_q];
            sdaOe_d  = ~regs_q[ptr_q][7];
          end
        end
`endif
        default: begin
          state_d = IDLE;
          sdaOe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      sdaOe_q     <= 1'b0;
      wrStb_q     <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      hostRdata_q <= '0;
      for (int i = 0; i < 256; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sdaOe_q     <= sdaOe_d;
      wrStb_q     <= wrEn;
      hostRdata_q <= regs_q[HOST_ADDR];
      if (wrEn) begin
        regs_q[ptr_q] <= byteIn;
        wrAddr_q      <= ptr_q;
        wrData_q      <= byteIn;
      end
    end
  end

  assign SDA_OE     = sdaOe_q;
  assign WR_STB     = wrStb_q;
  assign WR_ADDR    = wrAddr_q;
  assign WR_DATA    = wrData_q;
  assign HOST_RDATA = hostRdata_q;
  assign BUSY       = (state_q != IDLE) && (state_q != IGNORE);

endmodule
